// File: rtl/ecpu_lsu_pkg.sv
// ecpu_lsu_pkg: shared types and defaults for the eCPU load/store unit.
package ecpu_lsu_pkg;
   typedef enum logic [1:0] {MEM_BYTE = 2'b00, MEM_HALF = 2'b01, MEM_WORD = 2'b10} mem_size_t;
   typedef enum logic [1:0] {IDLE, BUS, RESP} lsu_state_t;
   localparam int LSU_TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and lane extract/extension for loads.
module lsu_align
   import ecpu_lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_off,
   input  logic        i_uns,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_sel,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_misalign
);
   logic [7:0]  w_b;
   logic [15:0] w_h;
   always_comb begin
      w_b        = i_rdata[{i_off, 3'b000} +: 8];
      w_h        = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
      o_misalign = (i_size == MEM_HALF && i_off[0]) || (i_size == MEM_WORD && i_off != 2'b00) ||
                   i_size == 2'b11;
      o_sel      = i_size == MEM_BYTE ? 4'b0001 << i_off :
                   i_size == MEM_HALF ? 4'b0011 << i_off :
                   i_size == MEM_WORD ? 4'b1111 : 4'b0000;
      o_wdata    = i_size == MEM_BYTE ? {4{i_wdata[7:0]}} :
                   i_size == MEM_HALF ? {2{i_wdata[15:0]}} : i_wdata;
      o_rdata    = i_size == MEM_BYTE ? {{24{!i_uns && w_b[7]}}, w_b} :
                   i_size == MEM_HALF ? {{16{!i_uns && w_h[15]}}, w_h} : i_rdata;
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: eCPU memory stage; turns one load/store into a Wishbone classic
// cycle with lane steering, load extension and misalign/error/timeout faults.
module load_store_unit
   import ecpu_lsu_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_i,
   input  logic                    we_i,
   input  logic [1:0]              size_i,
   input  logic                    unsigned_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic                    stall_o,
   output logic                    done_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    misalign_o,
   output logic                    bus_err_o,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   input  logic                    wb_ack_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_err_i
);
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
   lsu_state_t r_state, w_next;
   logic r_we, r_uns;
   logic [1:0] r_size, r_off;
   logic [31:0] r_cnt;
   logic w_idle, w_bus, w_mis, w_to, w_fin;
   logic [DATA_WIDTH/8-1:0] w_sel;
   logic [DATA_WIDTH-1:0] w_wdata, w_ext;
   assign w_idle  = r_state == IDLE;
   assign w_bus   = r_state == BUS;
   assign w_to    = TIMEOUT_CYCLES > 0 && r_cnt == TO_LAST;
   assign w_fin   = wb_err_i || wb_ack_i || w_to;
   assign stall_o = (w_idle && req_i) || w_bus;
   // Live request fields steer the store side in IDLE; latched fields drive the load extract.
   lsu_align u_align (
      .i_size     (w_idle ? size_i : r_size),
      .i_off      (w_idle ? addr_i[1:0] : r_off),
      .i_uns      (r_uns),
      .i_wdata    (wdata_i),
      .i_rdata    (wb_dat_i),
      .o_sel      (w_sel),
      .o_wdata    (w_wdata),
      .o_rdata    (w_ext),
      .o_misalign (w_mis)
   );
   always_comb begin
      w_next = w_idle ? (req_i ? (w_mis ? RESP : BUS) : IDLE) : w_bus ? (w_fin ? RESP : BUS) : IDLE;
   end
   always_ff @(posedge clk_i) begin
      r_state <= rst_i ? IDLE : w_next;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         {wb_cyc_o, wb_stb_o, wb_we_o, done_o, misalign_o, bus_err_o} <= '0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         wb_sel_o <= '0;
         rdata_o  <= '0;
         r_we     <= 1'b0;
         r_uns    <= 1'b0;
         r_size   <= '0;
         r_off    <= '0;
         r_cnt    <= '0;
      end else begin
         done_o     <= 1'b0;
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
         rdata_o    <= '0;
         if (w_idle && req_i) begin
            r_we       <= we_i;
            r_uns      <= unsigned_i;
            r_size     <= size_i;
            r_off      <= addr_i[1:0];
            done_o     <= w_mis;
            misalign_o <= w_mis;
            wb_cyc_o   <= !w_mis;
            wb_stb_o   <= !w_mis;
            wb_we_o    <= !w_mis && we_i;
            wb_adr_o   <= w_mis ? '0 : {addr_i[ADDR_WIDTH-1:2], 2'b00};
            wb_sel_o   <= w_mis ? '0 : w_sel;
            wb_dat_o   <= w_mis ? '0 : w_wdata;
         end
         if (w_bus) begin
            r_cnt <= w_fin ? '0 : r_cnt + 1'b1;
            if (w_fin) begin
               {wb_cyc_o, wb_stb_o, wb_we_o} <= '0;
               wb_adr_o  <= '0;
               wb_dat_o  <= '0;
               wb_sel_o  <= '0;
               done_o    <= 1'b1;
               bus_err_o <= wb_err_i || !wb_ack_i;
               rdata_o   <= (wb_ack_i && !wb_err_i && !r_we) ? w_ext : '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit.
module tb_load_store_unit;
   logic        clk = 0, rst_i = 0, req_i = 0, we_i = 0, unsigned_i = 0;
   logic [1:0]  size_i = 0;
   logic [31:0] addr_i = 0, wdata_i = 0, rdata_o, wb_adr_o, wb_dat_o, wb_dat_i = 0;
   logic        stall_o, done_o, misalign_o, bus_err_o, wb_cyc_o, wb_stb_o, wb_we_o;
   logic        wb_ack_i = 0, wb_err_i = 0;
   logic [3:0]  wb_sel_o;
   int n_checks = 0, n_fail = 0;

   load_store_unit dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
      .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
      .done_o(done_o), .rdata_o(rdata_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
      .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
      .wb_err_i(wb_err_i)
   );

   always #5 clk = ~clk;

   // Drives one request and plays the slave: mode 0 ack, 1 err+ack, 2 silent.
   // lat counts negedges from the request cycle to done_o (-1 if never seen).
   task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] sd,
                         input int mode, output logic [31:0] adr, output logic [31:0] dat,
                         output logic [31:0] rd, output logic [3:0] sel, output logic wwe,
                         output logic mis, output logic be, output int ncyc, output int lat);
      bit got = 0;
      adr = 0; dat = 0; rd = 0; sel = 0; wwe = 0; mis = 0; be = 0; ncyc = 0; lat = -1;
      @(negedge clk);
      req_i = 1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = addr; wdata_i = wd;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge clk);
         if (wb_cyc_o) begin
            ncyc++; adr = wb_adr_o; dat = wb_dat_o; sel = wb_sel_o; wwe = wb_we_o;
            wb_ack_i = (mode != 2); wb_err_i = (mode == 1); wb_dat_i = sd;
         end else begin
            wb_ack_i = 0; wb_err_i = 0;
         end
         if (done_o) begin
            got = 1; lat = i; rd = rdata_o; mis = misalign_o; be = bus_err_o; req_i = 0;
         end
      end
      req_i = 0; wb_ack_i = 0; wb_err_i = 0;
   endtask

   task automatic test_reset();
      rst_i = 1;
      repeat (2) @(negedge clk);
      rst_i = 0;
      #1;
      if (wb_cyc_o !== 1'b0) begin $display("FAIL reset_cyc: got %b want 0", wb_cyc_o); n_fail++; end
      n_checks++;
      if (wb_stb_o !== 1'b0) begin $display("FAIL reset_stb: got %b want 0", wb_stb_o); n_fail++; end
      n_checks++;
      if (done_o !== 1'b0) begin $display("FAIL reset_done: got %b want 0", done_o); n_fail++; end
      n_checks++;
      if (stall_o !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", stall_o); n_fail++; end
      n_checks++;
      if (rdata_o !== 32'h0) begin $display("FAIL reset_rdata: got %h want 0", rdata_o); n_fail++; end
      n_checks++;
      if (wb_sel_o !== 4'h0) begin $display("FAIL reset_sel: got %h want 0", wb_sel_o); n_fail++; end
      n_checks++;
   endtask

   task automatic test_word();
      logic [31:0] adr, dat, rd; logic [3:0] sel; logic wwe, mis, be; int ncyc, lat;
      access(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (adr !== 32'h100) begin $display("FAIL sw_adr: got %h want 00000100", adr); n_fail++; end
      n_checks++;
      if (sel !== 4'hF) begin $display("FAIL sw_sel: got %h want f", sel); n_fail++; end
      n_checks++;
      if (dat !== 32'hDEADBEEF) begin $display("FAIL sw_dat: got %h want deadbeef", dat); n_fail++; end
      n_checks++;
      if (wwe !== 1'b1) begin $display("FAIL sw_we: got %b want 1", wwe); n_fail++; end
      n_checks++;
      if (rd !== 32'h0) begin $display("FAIL sw_rdata: got %h want 0", rd); n_fail++; end
      n_checks++;
      access(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (lat !== 2) begin $display("FAIL lw_latency: got %0d want 2", lat); n_fail++; end
      n_checks++;
      if (rd !== 32'hDEADBEEF) begin $display("FAIL lw_rdata: got %h want deadbeef", rd); n_fail++; end
      n_checks++;
      if (wwe !== 1'b0) begin $display("FAIL lw_we: got %b want 0", wwe); n_fail++; end
      n_checks++;
      if (ncyc !== 1) begin $display("FAIL lw_cyc_len: got %0d want 1", ncyc); n_fail++; end
      n_checks++;
      @(negedge clk);
      if (done_o !== 1'b0) begin $display("FAIL done_pulse: got %b want 0", done_o); n_fail++; end
      n_checks++;
      if (rdata_o !== 32'h0) begin $display("FAIL rdata_clear: got %h want 0", rdata_o); n_fail++; end
      n_checks++;
   endtask

   task automatic test_byte();
      logic [31:0] adr, dat, rd; logic [3:0] sel; logic wwe, mis, be; int ncyc, lat;
      access(1, 2'b00, 0, 32'h103, 32'h00000080, 32'h0, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (sel !== 4'b1000) begin $display("FAIL sb_sel: got %b want 1000", sel); n_fail++; end
      n_checks++;
      if (dat !== 32'h80808080) begin $display("FAIL sb_dat: got %h want 80808080", dat); n_fail++; end
      n_checks++;
      if (adr !== 32'h100) begin $display("FAIL sb_adr: got %h want 00000100", adr); n_fail++; end
      n_checks++;
      access(0, 2'b00, 0, 32'h103, 32'h0, 32'h80ADBEEF, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (rd !== 32'hFFFFFF80) begin $display("FAIL lb_signed: got %h want ffffff80", rd); n_fail++; end
      n_checks++;
      access(0, 2'b00, 1, 32'h103, 32'h0, 32'h80ADBEEF, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (rd !== 32'h00000080) begin $display("FAIL lbu: got %h want 00000080", rd); n_fail++; end
      n_checks++;
   endtask

   task automatic test_half();
      logic [31:0] adr, dat, rd; logic [3:0] sel; logic wwe, mis, be; int ncyc, lat;
      access(0, 2'b01, 0, 32'h102, 32'h0, 32'h80011234, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (rd !== 32'hFFFF8001) begin $display("FAIL lh_signed: got %h want ffff8001", rd); n_fail++; end
      n_checks++;
      if (sel !== 4'b1100) begin $display("FAIL lh_sel: got %b want 1100", sel); n_fail++; end
      n_checks++;
      access(0, 2'b01, 1, 32'h102, 32'h0, 32'h80011234, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (rd !== 32'h00008001) begin $display("FAIL lhu: got %h want 00008001", rd); n_fail++; end
      n_checks++;
      access(0, 2'b01, 0, 32'h100, 32'h0, 32'h80011234, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (rd !== 32'h00001234) begin $display("FAIL lh_low: got %h want 00001234", rd); n_fail++; end
      n_checks++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] adr, dat, rd; logic [3:0] sel; logic wwe, mis, be; int ncyc, lat;
      access(1, 2'b00, 0, 32'h101, 32'h123456A5, 32'h0, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (sel !== 4'b0010) begin $display("FAIL sb1_sel: got %b want 0010", sel); n_fail++; end
      n_checks++;
      if (dat !== 32'hA5A5A5A5) begin $display("FAIL sb1_dat: got %h want a5a5a5a5", dat); n_fail++; end
      n_checks++;
      access(1, 2'b01, 0, 32'h102, 32'h0000BEEF, 32'h0, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (sel !== 4'b1100) begin $display("FAIL sh_sel: got %b want 1100", sel); n_fail++; end
      n_checks++;
      if (dat !== 32'hBEEFBEEF) begin $display("FAIL sh_dat: got %h want beefbeef", dat); n_fail++; end
      n_checks++;
      access(0, 2'b00, 0, 32'h101, 32'h0, 32'h1234A578, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (rd !== 32'hFFFFFFA5) begin $display("FAIL lb1_signed: got %h want ffffffa5", rd); n_fail++; end
      n_checks++;
      if (lat !== 2) begin $display("FAIL b2b_latency: got %0d want 2", lat); n_fail++; end
      n_checks++;
   endtask

   task automatic test_misalign();
      logic [31:0] adr, dat, rd; logic [3:0] sel; logic wwe, mis, be; int ncyc, lat;
      access(0, 2'b10, 0, 32'h102, 32'h0, 32'hFFFFFFFF, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (ncyc !== 0) begin $display("FAIL mis_no_cyc: got %0d want 0", ncyc); n_fail++; end
      n_checks++;
      if (lat !== 1) begin $display("FAIL mis_latency: got %0d want 1", lat); n_fail++; end
      n_checks++;
      if (mis !== 1'b1) begin $display("FAIL mis_flag: got %b want 1", mis); n_fail++; end
      n_checks++;
      if (be !== 1'b0) begin $display("FAIL mis_buserr: got %b want 0", be); n_fail++; end
      n_checks++;
      if (rd !== 32'h0) begin $display("FAIL mis_rdata: got %h want 0", rd); n_fail++; end
      n_checks++;
      access(0, 2'b01, 0, 32'h101, 32'h0, 32'h0, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (mis !== 1'b1) begin $display("FAIL mis_half: got %b want 1", mis); n_fail++; end
      n_checks++;
      access(1, 2'b11, 0, 32'h100, 32'h0, 32'h0, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (mis !== 1'b1 || ncyc !== 0) begin
         $display("FAIL mis_reserved: got mis=%b cyc=%0d want mis=1 cyc=0", mis, ncyc); n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_bus_err();
      logic [31:0] adr, dat, rd; logic [3:0] sel; logic wwe, mis, be; int ncyc, lat;
      access(0, 2'b10, 0, 32'h10000, 32'h0, 32'h12345678, 1, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (adr !== 32'h10000) begin $display("FAIL err_adr: got %h want 00010000", adr); n_fail++; end
      n_checks++;
      if (lat !== 2) begin $display("FAIL err_latency: got %0d want 2", lat); n_fail++; end
      n_checks++;
      if (be !== 1'b1) begin $display("FAIL err_flag: got %b want 1", be); n_fail++; end
      n_checks++;
      if (mis !== 1'b0) begin $display("FAIL err_mis: got %b want 0", mis); n_fail++; end
      n_checks++;
      if (rd !== 32'h0) begin $display("FAIL err_rdata: got %h want 0", rd); n_fail++; end
      n_checks++;
      access(0, 2'b10, 0, 32'h10000, 32'h0, 32'h12345678, 2, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (ncyc !== 16) begin $display("FAIL to_cyc_len: got %0d want 16", ncyc); n_fail++; end
      n_checks++;
      if (lat !== 17) begin $display("FAIL to_latency: got %0d want 17", lat); n_fail++; end
      n_checks++;
      if (be !== 1'b1 || mis !== 1'b0) begin
         $display("FAIL to_flags: got be=%b mis=%b want be=1 mis=0", be, mis); n_fail++;
      end
      n_checks++;
      if (rd !== 32'h0) begin $display("FAIL to_rdata: got %h want 0", rd); n_fail++; end
      n_checks++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] adr, dat, rd; logic [3:0] sel; logic wwe, mis, be; int ncyc, lat;
      bit seen = 0;
      @(negedge clk);
      req_i = 1; we_i = 0; size_i = 2'b10; unsigned_i = 0; addr_i = 32'h200;
      #1;
      if (stall_o !== 1'b1) begin $display("FAIL stall_req: got %b want 1", stall_o); n_fail++; end
      n_checks++;
      @(negedge clk);
      if (wb_cyc_o !== 1'b1) begin $display("FAIL rm_cyc_up: got %b want 1", wb_cyc_o); n_fail++; end
      n_checks++;
      if (stall_o !== 1'b1) begin $display("FAIL stall_bus: got %b want 1", stall_o); n_fail++; end
      n_checks++;
      rst_i = 1; req_i = 0;
      @(negedge clk);
      if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
         $display("FAIL rm_cyc_drop: got cyc=%b stb=%b want 0 0", wb_cyc_o, wb_stb_o); n_fail++;
      end
      n_checks++;
      if (stall_o !== 1'b0) begin $display("FAIL rm_stall: got %b want 0", stall_o); n_fail++; end
      n_checks++;
      rst_i = 0;
      if (done_o) seen = 1;
      repeat (3) begin
         @(negedge clk);
         if (done_o) seen = 1;
      end
      if (seen !== 1'b0) begin $display("FAIL rm_no_done: got %b want 0", seen); n_fail++; end
      n_checks++;
      access(0, 2'b10, 0, 32'h200, 32'h0, 32'hCAFEF00D, 0, adr, dat, rd, sel, wwe, mis, be, ncyc, lat);
      if (rd !== 32'hCAFEF00D || lat !== 2) begin
         $display("FAIL rm_recover: got rdata=%h lat=%0d want cafef00d 2", rd, lat); n_fail++;
      end
      n_checks++;
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_back_to_back();
      test_misalign();
      test_bus_err();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
